fib_ctrl: RTL and testbench

FIB_CTRL -- requirements
Module: fib_ctrl

---
 rtl/fib_pkg.sv | 21 ++
 rtl/fib_ctrl.sv | 144 ++++++++++++++
 tb/tb_fib_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci controller: FSM encoding and the
// register-file indices it uses as working registers.
package fib_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT0 = 3'd1,
    INIT1 = 3'd2,
    CHECK = 3'd3,
    ADD   = 3'd4,
    MOV0  = 3'd5,
    MOV1  = 3'd6,
    DONE  = 3'd7
  } state_t;

  // r0 holds F(k-1), r1 holds F(k), r2 is the scratch sum
  localparam logic [3:0] R0 = 4'd0;
  localparam logic [3:0] R1 = 4'd1;
  localparam logic [3:0] R2 = 4'd2;

endpackage : fib_pkg

// File: rtl/fib_ctrl.sv
// Fibonacci sequencer driving an external 16-entry register file; leaves
// F(n) mod 2^bw in r1 and flags any carry-out seen during the job.
module fib_ctrl
  import fib_pkg::*;
#(
  parameter int bw = 8,
  parameter int nw = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [nw-1:0] n,
  input  logic [bw-1:0] adata,
  input  logic [bw-1:0] bdata,
  output logic          rw,
  output logic [3:0]    da,
  output logic [3:0]    aa,
  output logic [3:0]    ba,
  output logic [bw-1:0] din,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  state_t        state_r;
  state_t        next_s;
  logic [nw-1:0] cnt_r;
  logic          ovf_r;
  logic [bw:0]   sum_s;

  assign sum_s = {1'b0, adata} + {1'b0, bdata};
  assign ovf   = ovf_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Iteration counter and sticky overflow; both only change inside a job
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {nw{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r <= n;
            ovf_r <= 1'b0;
          end
        end
        ADD: begin
          if (sum_s[bw]) begin
            ovf_r <= 1'b1;
          end
        end
        MOV1: begin
          cnt_r <= cnt_r - {{(nw-1){1'b0}}, 1'b1};
        end
        default: begin
          cnt_r <= cnt_r;
          ovf_r <= ovf_r;
        end
      endcase
    end
  end

  // Next-state and Moore output decode; register-file port defaults to idle
  always_comb begin
    next_s = state_r;
    rw     = 1'b0;
    da     = 4'd0;
    aa     = 4'd0;
    ba     = 4'd0;
    din    = {bw{1'b0}};
    busy   = 1'b1;
    done   = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_s = INIT0;
        end else begin
          next_s = IDLE;
        end
      end
      INIT0: begin
        rw     = 1'b1;
        da     = R0;
        din    = {{(bw-1){1'b0}}, 1'b1};
        next_s = INIT1;
      end
      INIT1: begin
        rw     = 1'b1;
        da     = R1;
        din    = {bw{1'b0}};
        next_s = CHECK;
      end
      CHECK: begin
        if (cnt_r == {nw{1'b0}}) begin
          next_s = DONE;
        end else begin
          next_s = ADD;
        end
      end
      ADD: begin
        aa     = R0;
        ba     = R1;
        rw     = 1'b1;
        da     = R2;
        din    = sum_s[bw-1:0];
        next_s = MOV0;
      end
      MOV0: begin
        aa     = R1;
        rw     = 1'b1;
        da     = R0;
        din    = adata;
        next_s = MOV1;
      end
      MOV1: begin
        aa     = R2;
        rw     = 1'b1;
        da     = R1;
        din    = adata;
        next_s = CHECK;
      end
      DONE: begin
        busy   = 1'b0;
        done   = 1'b1;
        next_s = IDLE;
      end
      default: begin
        busy   = 1'b0;
        next_s = IDLE;
      end
    endcase
  end

endmodule : fib_ctrl

// File: tb/tb_fib_ctrl.sv
// Directed bench for fib_ctrl with a behavioural 16x8 register file attached;
// expected results are hand-computed Fibonacci values and cycle counts.
module tb_fib_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] n;
  logic [7:0] adata;
  logic [7:0] bdata;
  logic       rw;
  logic [3:0] da;
  logic [3:0] aa;
  logic [3:0] ba;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       ovf;

  int n_checks;
  int n_errors;

  logic [7:0] rf [16];

  fib_ctrl #(.bw(8), .nw(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .n    (n),
    .adata(adata),
    .bdata(bdata),
    .rw   (rw),
    .da   (da),
    .aa   (aa),
    .ba   (ba),
    .din  (din),
    .busy (busy),
    .done (done),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file: active-high reset taken from ~rst
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'd0;
    end else if (rw) begin
      rf[da] <= din;
    end
  end

  assign adata = rf[aa];
  assign bdata = rf[ba];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Launch a job at edge 0 and wait for done; glitch>0 pulses a second start
  // with n=9 in that cycle, hold keeps start high the whole time.
  task automatic run_job(input string tag, input int nval, input int exp_cycle,
                         input int exp_r1, input int exp_ovf,
                         input int glitch, input bit hold);
    int  c;
    bit  found;
    c     = 0;
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    n     = 4'(nval);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    while (!found && c < 200) begin
      @(negedge clk);
      c++;
      if (c == glitch) begin
        start = 1'b1;
        n     = 4'd9;
      end else if (!hold) begin
        start = 1'b0;
      end
      if (done) begin
        found = 1'b1;
      end else if (c == 2) begin
        check_val({tag, "_busy_mid"}, int'(busy), 1);
      end
    end
    check_val({tag, "_done_cycle"}, found ? c : -1, exp_cycle);
    check_val({tag, "_r1"}, int'(rf[1]), exp_r1);
    check_val({tag, "_ovf"}, int'(ovf), exp_ovf);
    check_val({tag, "_busy_at_done"}, int'(busy), 0);
    if (!hold) begin
      @(negedge clk);
      check_val({tag, "_done_pulse"}, int'(done), 0);
      check_val({tag, "_r1_hold"}, int'(rf[1]), exp_r1);
      check_val({tag, "_ovf_hold"}, int'(ovf), exp_ovf);
    end
  endtask

  initial begin
    int c;
    bit seen;
    n_checks = 0;
    n_errors = 0;
    start    = 1'b0;
    n        = 4'd0;
    rst      = 1'b0;
    #1;
    check_val("rst_rw", int'(rw), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_ovf", int'(ovf), 0);
    check_val("rst_da", int'(da), 0);
    check_val("rst_aa", int'(aa), 0);
    check_val("rst_ba", int'(ba), 0);
    check_val("rst_din", int'(din), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_busy", int'(busy), 0);

    run_job("n0", 0, 4, 0, 0, 0, 1'b0);
    run_job("n1", 1, 8, 1, 0, 0, 1'b0);
    run_job("n10", 10, 44, 55, 0, 0, 1'b0);
    run_job("n13", 13, 56, 233, 0, 0, 1'b0);
    run_job("n14", 14, 60, 121, 1, 0, 1'b0);
    run_job("n2", 2, 12, 1, 0, 0, 1'b0);
    run_job("n5_ign", 5, 24, 5, 0, 6, 1'b0);

    // reset during the first ADD of an n=7 job
    @(negedge clk);
    start = 1'b1;
    n     = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("add_rw", int'(rw), 1);
    check_val("add_da", int'(da), 2);
    rst = 1'b0;
    #1;
    check_val("abort_rw", int'(rw), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_din", int'(din), 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check_val("abort_quiet", int'(seen), 0);
    run_job("n3_post_rst", 3, 16, 2, 0, 0, 1'b0);

    // start held high: back-to-back jobs with a single IDLE cycle between
    run_job("hold1", 2, 12, 1, 0, 0, 1'b1);
    @(negedge clk);
    check_val("hold_idle_busy", int'(busy), 0);
    check_val("hold_idle_done", int'(done), 0);
    c    = 1;
    seen = 1'b0;
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      if (done) seen = 1'b1;
    end
    check_val("hold2_gap", seen ? c : -1, 13);
    check_val("hold2_r1", int'(rf[1]), 1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("final_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fib_ctrl
